// File: rtl/port_uart_tx.sv
// port_uart_tx: logs every change of the MCU 16-bit port bus. Each new value is queued in a
// small FIFO and sent as two 8N1 UART bytes, low byte first.
module port_uart_tx #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      port_in,
  input  logic                   ovf_clr,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } stateT;

  // Change detector and FIFO bookkeeping
  logic [DATA_W-1:0] lastQ;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;

  // Serializer
  stateT             state;
  logic [DATA_W-1:0] sh;
  logic              byteSel;
  logic [2:0]        bitIdx;
  logic [CLK_W-1:0]  clkCnt;

  logic       push;
  logic       pop;
  logic       accept;
  logic       drop;
  logic [7:0] curByte;
  logic [2:0] nextIdx;
  logic       bitDone;

  always_comb begin
    push    = (port_in != lastQ);
    pop     = (state == IDLE) && (count != '0);
    // A full FIFO still takes the word when the head leaves on the same edge.
    accept  = push && ((count < FULL_CNT) || pop);
    drop    = push && !accept;
    curByte = byteSel ? sh[15:8] : sh[7:0];
    nextIdx = bitIdx + 3'd1;
    bitDone = (clkCnt == LAST_CLK);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastQ    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      lastQ <= port_in;
      if (accept) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)    rdPtr <= rdPtr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop on the clearing edge wins so the lost word is never hidden.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: the word storage is not reset; the pointers and count alone decide which entries
  // are valid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr] <= port_in;
  end

  assign fifo_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      sh      <= '0;
      byteSel <= 1'b0;
      bitIdx  <= '0;
      clkCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sh      <= mem[rdPtr];
            byteSel <= 1'b0;
            clkCnt  <= '0;
            txd     <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (bitDone) begin
            clkCnt <= '0;
            bitIdx <= '0;
            txd    <= curByte[0];
            state  <= DATA;
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end

        DATA: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (bitIdx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= nextIdx;
              txd    <= curByte[nextIdx];
            end
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end

        STOP: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (!byteSel) begin
              // Low byte done; the high byte follows with no idle gap.
              byteSel <= 1'b1;
              txd     <= 1'b0;
              state   <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end

        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed bench for port_uart_tx; decodes the serial line mid-bit and
// compares against hand-computed frames.
module tb_port_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 20 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] port_in;
  logic        ovf_clr;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  port_uart_tx #(
    .DATA_W      (16),
    .DEPTH       (4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .port_in   (port_in),
    .ovf_clr   (ovf_clr),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Expected 20-bit line image of one word: start, low byte LSB first, stop, start, high byte, stop.
  function automatic logic [19:0] exp_frame(input logic [15:0] w);
    return {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
  endfunction

  // Starting on the negedge of frame cycle 0, sample every bit mid-way; ends on cycle FRAME.
  task automatic capture_frame(output logic [19:0] bits, output int busyCnt);
    bits    = '0;
    busyCnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (busy === 1'b1) busyCnt++;
      if (c % CPB == CPB / 2) bits[c / CPB] = txd;
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (txd === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (busy === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    port_in = 16'h0000;
    ovf_clr = 1'b0;
    #3;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (txd !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: txd=%b busy=%b want 1/0", txd, busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_single_word;
    logic [19:0] bits;
    int          bcnt;
    port_in = 16'hA55A;
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL single_push_count: got %0d want 1", fifo_count); end
    vectors++; if (txd !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL single_pre_pop: txd=%b busy=%b want 1/0", txd, busy); end
    @(negedge clk);
    vectors++; if (txd !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_start: txd=%b busy=%b want 0/1", txd, busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d want 0", fifo_count); end
    capture_frame(bits, bcnt);
    vectors++; if (bits !== exp_frame(16'hA55A)) begin miscompares++; $display("FAIL single_frame: got %05h want %05h", bits, exp_frame(16'hA55A)); end
    vectors++; if (bcnt != FRAME) begin miscompares++; $display("FAIL single_busy_len: got %0d want %0d", bcnt, FRAME); end
    vectors++; if (busy !== 1'b0 || txd !== 1'b1) begin miscompares++; $display("FAIL single_end: busy=%b txd=%b want 0/1", busy, txd); end
  endtask

  task automatic test_no_change;
    logic [19:0] bits;
    int          bcnt;
    int          bad;
    bit          found;
    port_in = 16'h1234;
    wait_start(8, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL nochg_start: no start bit seen, want one"); end
    capture_frame(bits, bcnt);
    vectors++; if (bits !== exp_frame(16'h1234)) begin miscompares++; $display("FAIL nochg_frame: got %05h want %05h", bits, exp_frame(16'h1234)); end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
      @(negedge clk);
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL nochg_quiet: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_overflow;
    logic [15:0] vals [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    logic [19:0] bits;
    int          bcnt;
    bit          found;
    port_in = 16'h0F0F;
    wait_start(8, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL ovf_start: no start bit seen, want one"); end
    for (int i = 0; i < 6; i++) begin
      port_in = vals[i];
      @(negedge clk);
    end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    wait_idle(FRAME + 10, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL ovf_idle: busy never fell, want 0"); end
    for (int i = 0; i < 4; i++) begin
      wait_start(8, found);
      vectors++; if (!found) begin miscompares++; $display("FAIL ovf_word_start: word %0d missing", i); end
      capture_frame(bits, bcnt);
      vectors++; if (bits !== exp_frame(vals[i])) begin miscompares++; $display("FAIL ovf_word: idx %0d got %05h want %05h", i, bits, exp_frame(vals[i])); end
    end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL ovf_drained: got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop_same_edge;
    logic [15:0] exp [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hC0DE};
    logic [19:0] bits;
    int          bcnt;
    bit          found;
    port_in = 16'hBEEF;
    wait_start(8, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL fullpop_start: no start bit seen, want one"); end
    for (int i = 0; i < 4; i++) begin
      port_in = exp[i];
      @(negedge clk);
    end
    wait_idle(FRAME + 10, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL fullpop_idle: busy never fell, want 0"); end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fullpop_pre: got %0d want 4", fifo_count); end
    port_in = 16'hC0DE;
    @(negedge clk);
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    vectors++; if (busy !== 1'b1 || txd !== 1'b0) begin miscompares++; $display("FAIL fullpop_started: busy=%b txd=%b want 1/0", busy, txd); end
    for (int i = 0; i < 5; i++) begin
      wait_start(8, found);
      vectors++; if (!found) begin miscompares++; $display("FAIL fullpop_word_start: word %0d missing", i); end
      capture_frame(bits, bcnt);
      vectors++; if (bits !== exp_frame(exp[i])) begin miscompares++; $display("FAIL fullpop_word: idx %0d got %05h want %05h", i, bits, exp_frame(exp[i])); end
    end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL fullpop_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] bits;
    int          bcnt;
    bit          found;
    port_in = 16'h1357;
    @(negedge clk);
    port_in = 16'h2468;
    wait_start(8, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL b2b_start: no start bit seen, want one"); end
    capture_frame(bits, bcnt);
    vectors++; if (bits !== exp_frame(16'h1357)) begin miscompares++; $display("FAIL b2b_first: got %05h want %05h", bits, exp_frame(16'h1357)); end
    vectors++; if (txd !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: txd=%b busy=%b want 1/0", txd, busy); end
    @(negedge clk);
    vectors++; if (txd !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start: txd=%b busy=%b want 0/1", txd, busy); end
    capture_frame(bits, bcnt);
    vectors++; if (bits !== exp_frame(16'h2468)) begin miscompares++; $display("FAIL b2b_second: got %05h want %05h", bits, exp_frame(16'h2468)); end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    bit found;
    port_in = 16'h7777;
    wait_start(8, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_start: no start bit seen, want one"); end
    for (int i = 1; i <= 5; i++) begin
      port_in = 16'(i * 16'h0101);
      @(negedge clk);
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_ovf: got %b want 1", overflow); end
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    port_in = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rstmid_lost: %0d active cycles, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_no_change();
    test_overflow();
    test_full_pop_same_edge();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
